imem_boot_loader: RTL

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader_pkg.sv | 23 ++
 rtl/imem_boot_loader_if.sv | 18 +
 rtl/imem_boot_loader_rst_stretch.sv | 51 +++++
 rtl/imem_boot_loader.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default sizing for the instruction-memory boot loader.
// Holds the loader state encoding and the default parameter values.
// Imported by the interface, the reset stretcher and the loader top.
package boot_pkg;

  localparam int DEF_INSTR_W    = 59;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_NREGS      = 32;
  localparam int DEF_IMEM_DEPTH = 64;
  localparam int DEF_REG_BASE   = 1;
  localparam int DEF_RST_HOLD   = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_REGS = 3'd1,
    ST_LOAD_IMEM = 3'd2,
    ST_CHECK     = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_DONE      = 3'd5,
    ST_ERROR     = 3'd6
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot image stream: valid/ready handshake carrying instruction-width words.
// Master is the image source, slave is the loader.
// A word transfers on any rising edge where s_valid && s_ready.
interface imem_boot_loader_if
  import boot_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W
) ();

  logic               s_valid;
  logic               s_ready;
  logic [INSTR_W-1:0] s_data;
  logic               s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/imem_boot_loader_rst_stretch.sv
// Holds the CPU reset for RST_HOLD cycles once the image is loaded, then drops it.
// Latency: cpu_rst falls RST_HOLD cycles after i_load; o_expire flags the last hold cycle.
// No backpressure; i_clear re-asserts cpu_rst and abandons any count in progress.
module boot_rst_stretch #(
  parameter int RST_HOLD = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expire,
  output logic o_cpu_rst
);

  localparam int CW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);

  logic [CW-1:0] r_cnt;
  logic          r_cpu_rst;
  logic          w_expire;

  // Count 1 means this is the final hold cycle.
  assign w_expire = (r_cnt == CW'(1));

  // Hold-cycle down-counter, armed when the loader enters RELEASE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(RST_HOLD);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // CPU reset stays high until the hold expires; any new boot raises it again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rst <= 1'b1;
    end else if (i_clear || i_load) begin
      r_cpu_rst <= 1'b1;
    end else if (w_expire) begin
      r_cpu_rst <= 1'b0;
    end
  end

  assign o_expire  = w_expire;
  assign o_cpu_rst = r_cpu_rst;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a boot image into the register bank then instruction memory, then releases the CPU.
// Latency: each accepted word is written exactly one cycle later; all outputs registered.
// Backpressure: s_ready only in load/check states; s_valid stalls simply delay the sequence.
// Optional BOOT_LOADER_CHECKSUM_EN adds a CHECK state verifying the XOR of all imem words.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NREGS      = DEF_NREGS,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int REG_BASE   = DEF_REG_BASE,
  parameter int RST_HOLD   = DEF_RST_HOLD
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  imem_boot_loader_if.slave             s,
  output logic                          rf_we,
  output logic [$clog2(NREGS)-1:0]      rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          im_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] im_waddr,
  output logic [INSTR_W-1:0]            im_wdata,
  output logic                          cpu_rst,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int RAW = $clog2(NREGS);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam logic [RAW-1:0] RF_BASE = RAW'(REG_BASE);
  localparam logic [RAW-1:0] RF_LAST = RAW'(NREGS - 1);
  localparam logic [IAW-1:0] IM_LAST = IAW'(IMEM_DEPTH - 1);

  boot_state_t        r_state;
  boot_state_t        w_next;
  logic               r_s_ready, r_busy, r_done, r_err;
  logic               r_rf_we, r_im_we;
  logic [RAW-1:0]     r_rf_k, r_rf_waddr, w_rf_addr;
  logic [DATA_W-1:0]  r_rf_wdata;
  logic [IAW-1:0]     r_im_k, r_im_waddr;
  logic [INSTR_W-1:0] r_im_wdata;
  logic               w_acc, w_restart, w_load, w_expire, w_cpu_rst;

  assign w_acc     = s.s_valid && r_s_ready;
  assign w_restart = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                               (r_state == ST_ERROR));
  assign w_rf_addr = RF_BASE + r_rf_k;
  assign w_load    = (w_next == ST_RELEASE) && (r_state != ST_RELEASE);

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0] r_csum;
  logic               w_csum_ok;
  assign w_csum_ok = (s.s_data == r_csum);

  // Running XOR of every accepted imem word; cleared when a boot starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
    end else if (w_restart) begin
      r_csum <= '0;
    end else if (w_acc && (r_state == ST_LOAD_IMEM)) begin
      r_csum <= r_csum ^ s.s_data;
    end
  end
`endif

  // Next-state decode; the final legal address without s_last is an overrun.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD_REGS;
      ST_LOAD_REGS: begin
        if (w_acc) begin
          if (s.s_last) w_next = ST_LOAD_IMEM;
          else if (w_rf_addr == RF_LAST) w_next = ST_ERROR;
        end
      end
      ST_LOAD_IMEM: begin
        if (w_acc) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          if (s.s_last) w_next = ST_CHECK;
`else
          if (s.s_last) w_next = ST_RELEASE;
`endif
          else if (r_im_k == IM_LAST) w_next = ST_ERROR;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHECK: if (w_acc) w_next = w_csum_ok ? ST_RELEASE : ST_ERROR;
`endif
      ST_RELEASE: if (w_expire) w_next = ST_DONE;
      ST_DONE, ST_ERROR: if (start) w_next = ST_LOAD_REGS;
      default: w_next = ST_IDLE;
    endcase
  end

  // State plus status flags, registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_s_ready <= (w_next == ST_LOAD_REGS) || (w_next == ST_LOAD_IMEM) ||
                   (w_next == ST_CHECK);
      r_busy    <= (w_next == ST_LOAD_REGS) || (w_next == ST_LOAD_IMEM) ||
                   (w_next == ST_CHECK) || (w_next == ST_RELEASE);
      r_done    <= (w_next == ST_DONE);
      r_err     <= (w_next == ST_ERROR);
    end
  end

  // Write strobes, addresses, data and phase word counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_we    <= 1'b0;
      r_im_we    <= 1'b0;
      r_rf_k     <= '0;
      r_im_k     <= '0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_im_waddr <= '0;
      r_im_wdata <= '0;
    end else begin
      r_rf_we <= w_acc && (r_state == ST_LOAD_REGS);
      r_im_we <= w_acc && (r_state == ST_LOAD_IMEM);
      if (w_restart) begin
        r_rf_k <= '0;
        r_im_k <= '0;
      end else if (w_acc && (r_state == ST_LOAD_REGS)) begin
        r_rf_waddr <= w_rf_addr;
        r_rf_wdata <= s.s_data[DATA_W-1:0];
        r_rf_k     <= r_rf_k + 1'b1;
      end else if (w_acc && (r_state == ST_LOAD_IMEM)) begin
        r_im_waddr <= r_im_k;
        r_im_wdata <= s.s_data;
        r_im_k     <= r_im_k + 1'b1;
      end
    end
  end

  boot_rst_stretch #(.RST_HOLD(RST_HOLD)) u_rst_stretch (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_clear   (w_restart),
    .o_expire  (w_expire),
    .o_cpu_rst (w_cpu_rst)
  );

  assign s.s_ready = r_s_ready;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign im_we     = r_im_we;
  assign im_waddr  = r_im_waddr;
  assign im_wdata  = r_im_wdata;
  assign cpu_rst   = w_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
